cv_pad_scanner: RTL and testbench
=================================

// Module: cv_pad_scanner
// PURPOSE
//  Host-side scanner for a physical ColecoVision hand controller on the UserIO port.
//  - Drives the two controller select lines: keypad select (pin 5) and joystick select (pin 8).
//  - Samples the returned active-low pins 1-4 and 6 and decodes the 4-bit keypad code.
//  - Presents a debounced MiSTer joystick word (same bit map as joystick_0) for the emu
//    joystick mux.
//  - Counterpart of the console-side controller emulation, which answers these selects.
// PARAMETERS
//  SETTLE_CYC  2048  clk_sys cycles a select is held low before sampling (>=2)
//  GAP_CYC     256   clk_sys cycles both selects held high between phases (>=1)
//  DEBOUNCE    2     consecutive identical raw frames required to update joy_out (1..7)
// PORTS
//  clk_sys    in   1   system clock
//  reset      in   1   asynchronous, active-high
//  en         in   1   scan enable (status-driven); 0 parks the scanner
//  pad_in     in   5   {pin6,pin4,pin3,pin2,pin1} from controller, active-low, async
//  sel_kp_n   out  1   keypad select (controller pin 5), active-low
//  sel_js_n   out  1   joystick select (controller pin 8), active-low
//  joy_out    out  20  [0]R [1]L [2]D [3]U [4]Fire1 [5]Fire2 [6]* [7]# [8..17]key0..9
//                      [18]Purple [19]Blue; active-high
//  joy_upd    out  1   one-cycle pulse when joy_out changes value
// BEHAVIOUR
//  Reset / async, active-high:
//   - sel_kp_n=1, sel_js_n=1, joy_out=0, joy_upd=0.
//   - FSM to IDLE; debounce count and raw-frame registers cleared.
//  Input synchronisation: pad_in passes through a 2-flop synchroniser before any use.
//  FSM states, one counter of width $clog2(max(SETTLE_CYC,GAP_CYC)+1):
//   IDLE:
//    - selects high.
//    - en=1 -> GAP1 with counter=0.
//   GAP1:
//    - selects high for GAP_CYC cycles -> SEL_JS.
//   SEL_JS:
//    - sel_js_n=0 for SETTLE_CYC cycles.
//    - On the last cycle latch js_raw={pin6,pin1..pin4} inverted -> GAP2.
//   GAP2:
//    - selects high for GAP_CYC cycles -> SEL_KP.
//   SEL_KP:
//    - sel_kp_n=0 for SETTLE_CYC cycles.
//    - On the last cycle latch kp_code={pin1,pin2,pin3,pin4} and fire2=~pin6 -> EVAL.
//   EVAL (1 cycle):
//    - Build the candidate frame, run debounce -> GAP1.
//  Frame period = 2*(GAP_CYC+SETTLE_CYC)+1 cycles.
//  Break-before-make: sel_kp_n and sel_js_n are never both 0 in any cycle, including
//  across reset and en transitions.
//  Joystick decode: U=~pin1, D=~pin2, L=~pin3, R=~pin4, Fire1=~pin6.
//  Keypad decode of {p1,p2,p3,p4}; exactly one key bit is set, or none:
//   - Digits: 0011=0, 1110=1, 1101=2, 0110=3, 0001=4, 1001=5, 0111=6, 1100=7, 1000=8, 1011=9.
//   - Others: 1010=*, 0101=#, 0100=Purple, 0010=Blue.
//   - 1111 and the unused code 0000 decode to no key.
//  Debounce:
//   - Candidate equals the previous raw frame: count saturates at DEBOUNCE.
//   - Otherwise count=1.
//   - When count reaches DEBOUNCE and candidate != joy_out: joy_out<=candidate and
//     joy_upd=1 for that one cycle.
//   - DEBOUNCE=1 updates on every differing frame.
//  en deasserted mid-scan:
//   - Next cycle: selects high, FSM to IDLE, joy_out<=0.
//   - joy_upd pulses if joy_out was nonzero.
//   - Partial frame is discarded.
//  Re-enable restarts at GAP1; no stale frame is ever published.
//  Latency from a stable controller change to joy_out:
//   - At most (DEBOUNCE+1) frame periods + 3 cycles.
//   - 3 cycles = synchroniser + EVAL.
//  Reset asserted mid-operation: outputs take reset values immediately (asynchronous).
// TESTING
//  1. Reset, en=1, pad_in all 1 -> selects strictly alternate with GAP between phases;
//     joy_out stays 0; no joy_upd.
//  2. Model answers sel_js with pin1=0 and pin6=0, DEBOUNCE=2 -> joy_out=0x00018 (U+Fire1)
//     after the 2nd frame; joy_upd pulses once.
//  3. Model answers sel_kp with code 1110 and pin6=0 -> joy_out[9] (key1) and joy_out[5]
//     set; code 0000 -> no key bit.
//  4. Sweep all 16 keypad codes -> exactly the mapped bit or none; never two key bits set.
//  5. Glitch one frame (code 0101 then back to 1111) with DEBOUNCE=2 -> joy_out unchanged;
//     no joy_upd.
//  6. Drop en during SEL_KP, and separately assert reset during SEL_JS -> selects high
//     next cycle (reset: same cycle); joy_out=0; both selects never low together.

Source files
------------

// File: rtl/cv_pad_scanner.sv
// Host-side ColecoVision pad scanner: alternates joystick/keypad selects and decodes the pad.
// Publishes a debounced MiSTer joystick word; joy_upd pulses on every published change.
module cv_pad_scanner #(
  parameter int SETTLE_CYC = 2048,
  parameter int GAP_CYC    = 256,
  parameter int DEBOUNCE   = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  pad_in,
  output logic        sel_kp_n,
  output logic        sel_js_n,
  output logic [19:0] joy_out,
  output logic        joy_upd
);

  localparam int CNT_MAX = (SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [2:0]    DB_MAX      = 3'(DEBOUNCE);

  typedef enum logic [2:0] {
    IDLE,
    GAP1,
    SEL_JS,
    GAP2,
    SEL_KP,
    EVAL
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  logic [4:0]  pad_s1;
  logic [4:0]  pad_s2;

  logic [4:0]  js_raw;
  logic [3:0]  kp_code;
  logic        fire2;

  logic        latch_js;
  logic        latch_kp;
  logic        eval;

  logic [13:0] key_vec;
  logic [19:0] cand;
  logic [19:0] prev_raw;
  logic [2:0]  db_cnt;
  logic [2:0]  db_cnt_nxt;
  logic        publish;

  // Pads idle high, so the synchroniser resets to all ones.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pad_s1 <= '1;
      pad_s2 <= '1;
    end else begin
      pad_s1 <= pad_in;
      pad_s2 <= pad_s1;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    latch_js  = 1'b0;
    latch_kp  = 1'b0;
    eval      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (en) state_nxt = GAP1;
      end
      GAP1: begin
        if (cnt == GAP_LAST) begin
          state_nxt = SEL_JS;
          cnt_nxt   = '0;
        end
      end
      SEL_JS: begin
        if (cnt == SETTLE_LAST) begin
          latch_js  = 1'b1;
          state_nxt = GAP2;
          cnt_nxt   = '0;
        end
      end
      GAP2: begin
        if (cnt == GAP_LAST) begin
          state_nxt = SEL_KP;
          cnt_nxt   = '0;
        end
      end
      SEL_KP: begin
        if (cnt == SETTLE_LAST) begin
          latch_kp  = 1'b1;
          state_nxt = EVAL;
          cnt_nxt   = '0;
        end
      end
      EVAL: begin
        eval      = 1'b1;
        state_nxt = GAP1;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // Dropping enable abandons whatever partial frame is in flight.
    if (!en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      latch_js  = 1'b0;
      latch_kp  = 1'b0;
      eval      = 1'b0;
    end
  end

  // Selects decode from the next state so only one can ever be low per cycle.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sel_js_n <= 1'b1;
      sel_kp_n <= 1'b1;
    end else begin
      sel_js_n <= (state_nxt != SEL_JS);
      sel_kp_n <= (state_nxt != SEL_KP);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      js_raw  <= '0;
      kp_code <= 4'b1111;
      fire2   <= 1'b0;
    end else begin
      if (latch_js) js_raw <= ~{pad_s2[4], pad_s2[0], pad_s2[1], pad_s2[2], pad_s2[3]};
      if (latch_kp) begin
        kp_code <= {pad_s2[0], pad_s2[1], pad_s2[2], pad_s2[3]};
        fire2   <= ~pad_s2[4];
      end
    end
  end

  // key_vec: [0]* [1]# [2..11]key0..9 [12]Purple [13]Blue
  always_comb begin
    key_vec = '0;
    case (kp_code)
      4'b0011: key_vec[2]  = 1'b1;
      4'b1110: key_vec[3]  = 1'b1;
      4'b1101: key_vec[4]  = 1'b1;
      4'b0110: key_vec[5]  = 1'b1;
      4'b0001: key_vec[6]  = 1'b1;
      4'b1001: key_vec[7]  = 1'b1;
      4'b0111: key_vec[8]  = 1'b1;
      4'b1100: key_vec[9]  = 1'b1;
      4'b1000: key_vec[10] = 1'b1;
      4'b1011: key_vec[11] = 1'b1;
      4'b1010: key_vec[0]  = 1'b1;
      4'b0101: key_vec[1]  = 1'b1;
      4'b0100: key_vec[12] = 1'b1;
      4'b0010: key_vec[13] = 1'b1;
      default: key_vec     = '0;
    endcase
  end

  assign cand = {key_vec, fire2, js_raw};

  always_comb begin
    db_cnt_nxt = 3'd1;
    if (cand == prev_raw) begin
      db_cnt_nxt = (db_cnt >= DB_MAX) ? DB_MAX : db_cnt + 3'd1;
    end
    publish = eval && (db_cnt_nxt == DB_MAX) && (cand != joy_out);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      joy_out  <= '0;
      joy_upd  <= 1'b0;
      prev_raw <= '0;
      db_cnt   <= '0;
    end else begin
      joy_upd <= 1'b0;
      if (!en) begin
        joy_out  <= '0;
        joy_upd  <= |joy_out;
        prev_raw <= '0;
        db_cnt   <= '0;
      end else if (eval) begin
        prev_raw <= cand;
        db_cnt   <= db_cnt_nxt;
        if (publish) begin
          joy_out <= cand;
          joy_upd <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cv_pad_scanner.sv
// Directed bench for cv_pad_scanner with a behavioural controller answering the selects.
module tb_cv_pad_scanner;

  localparam int SETTLE = 8;
  localparam int GAP    = 4;
  localparam int DB     = 2;
  localparam int PERIOD = 2 * (GAP + SETTLE) + 1;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  pad_in;
  logic        sel_kp_n;
  logic        sel_js_n;
  logic [19:0] joy_out;
  logic        joy_upd;

  logic [4:0]  js_ans = 5'h1F;
  logic [4:0]  kp_ans = 5'h1F;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  int overlap = 0;
  int mon_err = 0;
  int phases = 0;
  bit mon_on = 1'b0;
  int gap_run = 0;
  int low_run = 0;
  int cur_ph = 0;
  int prev_ph = 0;
  int last_ph = 0;
  int u0;
  int lat;
  logic [4:0] code;

  cv_pad_scanner #(.SETTLE_CYC(SETTLE), .GAP_CYC(GAP), .DEBOUNCE(DB)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .en       (en),
    .pad_in   (pad_in),
    .sel_kp_n (sel_kp_n),
    .sel_js_n (sel_js_n),
    .joy_out  (joy_out),
    .joy_upd  (joy_upd)
  );

  always #5 clk_sys = ~clk_sys;

  // Controller: pins float high unless a select is pulled low.
  always_comb begin
    pad_in = 5'h1F;
    if (sel_js_n === 1'b0) pad_in = js_ans;
    else if (sel_kp_n === 1'b0) pad_in = kp_ans;
  end

  always @(negedge clk_sys) begin
    if (sel_kp_n === 1'b0 && sel_js_n === 1'b0) overlap++;
    if (joy_upd === 1'b1) upd_cnt++;
    if (mon_on) begin
      cur_ph = (sel_js_n === 1'b0) ? 1 : (sel_kp_n === 1'b0) ? 2 : 0;
      if (cur_ph == 0) begin
        if (prev_ph != 0 && low_run != SETTLE) mon_err++;
        low_run = 0;
        gap_run++;
      end else begin
        if (prev_ph == 0) begin
          if (last_ph == cur_ph) mon_err++;
          if (cur_ph == 2 && gap_run != GAP) mon_err++;
          if (cur_ph == 1 && last_ph == 2 && gap_run != GAP + 1) mon_err++;
          last_ph = cur_ph;
          phases++;
          gap_run = 0;
        end
        low_run++;
      end
      prev_ph = cur_ph;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_sel(input bit kp, input logic lvl, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_sys);
      if ((kp ? sel_kp_n : sel_js_n) === lvl) begin
        found = 1'b1;
        break;
      end
    end
    chk({"wait ", tag}, 32'(found), 32'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Expected joy_out for keypad code {p1,p2,p3,p4} with pin6 high.
  function automatic logic [19:0] exp_key(input logic [3:0] c);
    case (c)
      4'b0011: return 20'h00100;
      4'b1110: return 20'h00200;
      4'b1101: return 20'h00400;
      4'b0110: return 20'h00800;
      4'b0001: return 20'h01000;
      4'b1001: return 20'h02000;
      4'b0111: return 20'h04000;
      4'b1100: return 20'h08000;
      4'b1000: return 20'h10000;
      4'b1011: return 20'h20000;
      4'b1010: return 20'h00040;
      4'b0101: return 20'h00080;
      4'b0100: return 20'h40000;
      4'b0010: return 20'h80000;
      default: return 20'h00000;
    endcase
  endfunction

  function automatic logic [4:0] kp_pins(input logic [3:0] c, input logic p6);
    return {p6, c[0], c[1], c[2], c[3]};
  endfunction

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    cycles(3);
    chk("rst sel_kp_n", 32'(sel_kp_n), 32'd1);
    chk("rst sel_js_n", 32'(sel_js_n), 32'd1);
    chk("rst joy_out", 32'(joy_out), 32'd0);
    chk("rst joy_upd", 32'(joy_upd), 32'd0);

    // 1: idle controller, selects alternate with gaps
    reset  = 1'b0;
    mon_on = 1'b1;
    en     = 1'b1;
    cycles(6 * PERIOD);
    mon_on = 1'b0;
    chk("t1 joy_out", 32'(joy_out), 32'd0);
    chk("t1 no upd", 32'(upd_cnt), 32'd0);
    chk("t1 phase timing", 32'(mon_err), 32'd0);
    chk("t1 phase count", 32'(phases >= 11), 32'd1);

    // 2: joystick answers U + Fire1
    u0 = upd_cnt;
    js_ans = 5'b01110;
    lat = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk_sys);
      lat++;
      if (joy_upd === 1'b1) break;
    end
    chk("t2 latency min", 32'(lat > PERIOD), 32'd1);
    chk("t2 latency max", 32'(lat <= (DB + 1) * PERIOD + 3), 32'd1);
    cycles(3 * PERIOD);
    chk("t2 joy_out", 32'(joy_out), 32'h00018);
    chk("t2 one upd", 32'(upd_cnt - u0), 32'd1);

    // 3: keypad key1 with Fire2, then unused code 0000
    js_ans = 5'h1F;
    kp_ans = kp_pins(4'b1110, 1'b0);
    cycles(4 * PERIOD);
    chk("t3 key1 fire2", 32'(joy_out), 32'h00220);
    kp_ans = kp_pins(4'b0000, 1'b1);
    cycles(4 * PERIOD);
    chk("t3 code0000", 32'(joy_out), 32'h0);

    // 4: sweep all keypad codes
    for (int c = 0; c < 16; c++) begin
      code = 5'(c);
      kp_ans = kp_pins(code[3:0], 1'b1);
      cycles(4 * PERIOD);
      chk($sformatf("t4 code %04b", code[3:0]), 32'(joy_out), 32'(exp_key(code[3:0])));
      chk($sformatf("t4 onehot %04b", code[3:0]), 32'($countones(joy_out[19:6]) <= 1), 32'd1);
    end

    // 5: single-frame glitch is filtered; two frames publish
    kp_ans = 5'h1F;
    cycles(4 * PERIOD);
    chk("t5 idle", 32'(joy_out), 32'h0);
    u0 = upd_cnt;
    wait_sel(1'b1, 1'b0, "kp low g");
    kp_ans = kp_pins(4'b0101, 1'b1);
    wait_sel(1'b1, 1'b1, "kp high g");
    kp_ans = 5'h1F;
    cycles(4 * PERIOD);
    chk("t5 glitch joy_out", 32'(joy_out), 32'h0);
    chk("t5 glitch no upd", 32'(upd_cnt - u0), 32'd0);
    wait_sel(1'b1, 1'b0, "kp low a");
    kp_ans = kp_pins(4'b0101, 1'b1);
    wait_sel(1'b1, 1'b1, "kp high a");
    wait_sel(1'b1, 1'b0, "kp low b");
    wait_sel(1'b1, 1'b1, "kp high b");
    cycles(3);
    chk("t5 two frames", 32'(joy_out), 32'h00080);
    chk("t5 one upd", 32'(upd_cnt - u0), 32'd1);

    // 6a: drop enable during SEL_KP
    wait_sel(1'b1, 1'b0, "kp low en");
    cycles(2);
    en = 1'b0;
    cycles(1);
    chk("t6 en sel_kp_n", 32'(sel_kp_n), 32'd1);
    chk("t6 en sel_js_n", 32'(sel_js_n), 32'd1);
    chk("t6 en joy_out", 32'(joy_out), 32'h0);
    chk("t6 en joy_upd", 32'(joy_upd), 32'd1);
    cycles(1);
    chk("t6 en upd once", 32'(joy_upd), 32'd0);
    cycles(10);
    en = 1'b1;
    cycles(40);
    chk("t6 no stale", 32'(joy_out), 32'h0);
    cycles(60);
    chk("t6 re-enabled", 32'(joy_out), 32'h00080);

    // 6b: reset during SEL_JS clears outputs asynchronously
    wait_sel(1'b0, 1'b0, "js low rst");
    cycles(2);
    reset = 1'b1;
    #1;
    chk("t6 rst sel_js_n", 32'(sel_js_n), 32'd1);
    chk("t6 rst sel_kp_n", 32'(sel_kp_n), 32'd1);
    chk("t6 rst joy_out", 32'(joy_out), 32'h0);
    cycles(3);
    reset = 1'b0;
    cycles(2 * PERIOD);
    chk("no select overlap", 32'(overlap), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
